// File: rtl/cdma_a_wr.sv
// cdma_a_wr: aligned S2MM write DMA engine.
// Takes one {paddr,len} command, splits it into INCR bursts that never cross
// a 4 KiB page, streams the payload onto the W channel and pulses wr_done
// once every B response for the command has come back.
module cdma_a_wr #(
    parameter int BURST_LEN = 64,
    parameter int DATA_BITS = 256,
    parameter int ADDR_BITS = 64,
    parameter int ID_BITS   = 2,
    parameter int LEN_BITS  = 32
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDR_BITS-1:0]   wr_paddr,
    input  logic [LEN_BITS-1:0]    wr_len,
    output logic                   wr_done,
    output logic                   wr_err,
    output logic                   m_axi_ddr_awvalid,
    input  logic                   m_axi_ddr_awready,
    output logic [ADDR_BITS-1:0]   m_axi_ddr_awaddr,
    output logic [ID_BITS-1:0]     m_axi_ddr_awid,
    output logic [7:0]             m_axi_ddr_awlen,
    output logic [2:0]             m_axi_ddr_awsize,
    output logic [1:0]             m_axi_ddr_awburst,
    output logic                   m_axi_ddr_awlock,
    output logic [3:0]             m_axi_ddr_awcache,
    output logic [2:0]             m_axi_ddr_awprot,
    output logic                   m_axi_ddr_wvalid,
    input  logic                   m_axi_ddr_wready,
    output logic [DATA_BITS-1:0]   m_axi_ddr_wdata,
    output logic [DATA_BITS/8-1:0] m_axi_ddr_wstrb,
    output logic                   m_axi_ddr_wlast,
    input  logic                   m_axi_ddr_bvalid,
    output logic                   m_axi_ddr_bready,
    input  logic [1:0]             m_axi_ddr_bresp,
    input  logic [ID_BITS-1:0]     m_axi_ddr_bid,
    input  logic [DATA_BITS-1:0]   s_axis_ddr_tdata,
    input  logic [DATA_BITS/8-1:0] s_axis_ddr_tkeep,
    input  logic                   s_axis_ddr_tlast,
    input  logic                   s_axis_ddr_tvalid,
    output logic                   s_axis_ddr_tready
);

    localparam int BYTES      = DATA_BITS / 8;
    localparam int SZ         = $clog2(BYTES);
    localparam int CNT_W      = LEN_BITS - SZ + 1;
    localparam int PAGE_BEATS = 4096 / BYTES;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AW   = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           r_state;
    logic                 r_run;
    logic [ADDR_BITS-1:0] r_addr;
    logic [CNT_W-1:0]     r_remaining;
    logic [CNT_W-1:0]     r_wleft;
    logic [CNT_W-1:0]     r_outst;
    logic [SZ-1:0]        r_tail;
    logic                 r_err;

    logic [8:0]           r_fifo [0:3];
    logic [1:0]           r_wptr;
    logic [1:0]           r_rptr;
    logic [2:0]           r_fcount;
    logic [8:0]           r_wbeat;

    logic                 w_accept;
    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_b_hs;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [8:0]           w_head;
    logic                 w_w_last;
    logic [LEN_BITS:0]    w_len_ext;
    logic [CNT_W-1:0]     w_total;
    logic [CNT_W-1:0]     w_page_beats;
    logic [CNT_W-1:0]     w_burst_cnt;
    logic [8:0]           w_burst;
    logic [8:0]           w_burst_m1;
    logic [CNT_W-1:0]     w_outst_next;
    logic [BYTES-1:0]     w_tail_strb;
    logic                 w_unused_ok;

    // Handshakes and FIFO status
    assign w_accept     = wr_valid && wr_ready;
    assign w_aw_hs      = m_axi_ddr_awvalid && m_axi_ddr_awready;
    assign w_w_hs       = m_axi_ddr_wvalid && m_axi_ddr_wready;
    assign w_b_hs       = m_axi_ddr_bvalid && m_axi_ddr_bready;
    assign w_fifo_full  = (r_fcount == 3'd4);
    assign w_fifo_empty = (r_fcount == 3'd0);
    assign w_head       = r_fifo[r_rptr];
    assign w_w_last     = (r_wbeat == w_head - 9'd1);

    // Beat count of the command, rounded up to whole data words
    assign w_len_ext = {1'b0, wr_len} + (LEN_BITS + 1)'(BYTES - 1);
    assign w_total   = w_len_ext[LEN_BITS:SZ];

    // Beats left before the next 4 KiB page boundary
    assign w_page_beats = CNT_W'(PAGE_BEATS) - CNT_W'(r_addr[11:SZ]);

    // Next burst size: min(remaining, BURST_LEN, beats to page end)
    always_comb begin
        w_burst_cnt = r_remaining;
        if (w_burst_cnt > CNT_W'(BURST_LEN)) begin
            w_burst_cnt = CNT_W'(BURST_LEN);
        end
        if (w_burst_cnt > w_page_beats) begin
            w_burst_cnt = w_page_beats;
        end
    end

    assign w_burst    = w_burst_cnt[8:0];
    assign w_burst_m1 = w_burst - 9'd1;

    // Outstanding-burst count after this cycle's AW and B handshakes
    always_comb begin
        w_outst_next = r_outst;
        if (w_aw_hs && !w_b_hs) begin
            w_outst_next = r_outst + CNT_W'(1);
        end else if (!w_aw_hs && w_b_hs) begin
            w_outst_next = r_outst - CNT_W'(1);
        end
    end

    // Byte mask for a partial final beat: the low len%BYTES lanes
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_tail_strb
            assign w_tail_strb[gi] = (SZ'(gi) < r_tail);
        end
    endgenerate

    // Command FSM: accept, issue AW bursts, wait for the B responses, signal done.
    // A zero-length command passes through WAIT so done lands two cycles after accept.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_run       <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_tail      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_b_hs && m_axi_ddr_bresp[1]) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr      <= {wr_paddr[ADDR_BITS-1:SZ], {SZ{1'b0}}};
                        r_remaining <= w_total;
                        r_tail      <= wr_len[SZ-1:0];
                        r_err       <= 1'b0;
                        r_state     <= (w_total == '0) ? S_WAIT : S_AW;
                    end
                end
                S_AW: begin
                    if (w_aw_hs) begin
                        r_addr      <= r_addr + (ADDR_BITS'(w_burst) << SZ);
                        r_remaining <= r_remaining - CNT_W'(w_burst);
                        if (r_remaining == CNT_W'(w_burst)) begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_fifo_empty && (r_wleft == '0) && (w_outst_next == '0)) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outstanding AW bursts still waiting for their B response
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_outst <= '0;
        end else begin
            r_outst <= w_outst_next;
        end
    end

    // Burst FIFO storage: one entry (beat count) per accepted AW
    always_ff @(posedge aclk) begin
        if (w_aw_hs) begin
            r_fifo[r_wptr] <= w_burst;
        end
    end

    // Burst FIFO pointers, W beat position and command beats left to send
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_fcount <= '0;
            r_wbeat  <= '0;
            r_wleft  <= '0;
        end else begin
            if (w_aw_hs) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_w_hs && w_w_last) begin
                r_rptr <= r_rptr + 2'd1;
            end
            if (w_aw_hs && !(w_w_hs && w_w_last)) begin
                r_fcount <= r_fcount + 3'd1;
            end else if (!w_aw_hs && (w_w_hs && w_w_last)) begin
                r_fcount <= r_fcount - 3'd1;
            end
            if (w_w_hs) begin
                r_wbeat <= w_w_last ? 9'd0 : (r_wbeat + 9'd1);
            end
            if (w_accept) begin
                r_wleft <= w_total;
            end else if (w_w_hs) begin
                r_wleft <= r_wleft - CNT_W'(1);
            end
        end
    end

    // Command and status outputs
    assign wr_ready = r_run && (r_state == S_IDLE);
    assign wr_done  = (r_state == S_DONE);
    assign wr_err   = r_err;

    // AW channel: fields come from registers that only move on handshake, so they stay stable
    assign m_axi_ddr_awvalid = (r_state == S_AW) && !w_fifo_full;
    assign m_axi_ddr_awaddr  = r_addr;
    assign m_axi_ddr_awid    = '0;
    assign m_axi_ddr_awlen   = w_burst_m1[7:0];
    assign m_axi_ddr_awsize  = 3'(SZ);
    assign m_axi_ddr_awburst = 2'b01;
    assign m_axi_ddr_awlock  = 1'b0;
    assign m_axi_ddr_awcache = 4'b0011;
    assign m_axi_ddr_awprot  = 3'b000;

    // W channel: pass-through of the stream while the FIFO head burst is active
    assign m_axi_ddr_wvalid  = s_axis_ddr_tvalid && !w_fifo_empty;
    assign s_axis_ddr_tready = m_axi_ddr_wready && !w_fifo_empty;
    assign m_axi_ddr_wdata   = s_axis_ddr_tdata;
    assign m_axi_ddr_wlast   = w_w_last;
    assign m_axi_ddr_wstrb   = ((r_wleft == CNT_W'(1)) && (r_tail != '0)) ? w_tail_strb : '1;

    // B channel is always accepted once out of reset
    assign m_axi_ddr_bready  = r_run;

    // Inputs and bits that are intentionally ignored
    assign w_unused_ok = ^{wr_paddr[SZ-1:0], w_len_ext[SZ-1:0], w_burst_cnt[CNT_W-1:9],
                           w_burst_m1[8], m_axi_ddr_bresp[0], m_axi_ddr_bid,
                           s_axis_ddr_tkeep, s_axis_ddr_tlast};

endmodule

// File: tb/tb_cdma_a_wr.sv
// tb_cdma_a_wr: directed bench for cdma_a_wr with a small AXI slave and
// stream source model; every comparison is an immediate assertion.
module tb_cdma_a_wr;

    logic         clk = 1'b0;
    logic         aresetn;
    logic         wr_valid;
    logic         wr_ready;
    logic [63:0]  wr_paddr;
    logic [31:0]  wr_len;
    logic         wr_done;
    logic         wr_err;
    logic         awvalid, awready;
    logic [63:0]  awaddr;
    logic [1:0]   awid;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awlock;
    logic [3:0]   awcache;
    logic [2:0]   awprot;
    logic         wvalid, wready, wlast;
    logic [255:0] wdata;
    logic [31:0]  wstrb;
    logic         bvalid, bready;
    logic [1:0]   bresp;
    logic [1:0]   bid;
    logic [255:0] tdata;
    logic [31:0]  tkeep;
    logic         tlast, tvalid, tready;

    always #5 clk = ~clk;

    cdma_a_wr dut (
        .aclk(clk), .aresetn(aresetn),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_paddr(wr_paddr), .wr_len(wr_len),
        .wr_done(wr_done), .wr_err(wr_err),
        .m_axi_ddr_awvalid(awvalid), .m_axi_ddr_awready(awready), .m_axi_ddr_awaddr(awaddr),
        .m_axi_ddr_awid(awid), .m_axi_ddr_awlen(awlen), .m_axi_ddr_awsize(awsize),
        .m_axi_ddr_awburst(awburst), .m_axi_ddr_awlock(awlock), .m_axi_ddr_awcache(awcache),
        .m_axi_ddr_awprot(awprot),
        .m_axi_ddr_wvalid(wvalid), .m_axi_ddr_wready(wready), .m_axi_ddr_wdata(wdata),
        .m_axi_ddr_wstrb(wstrb), .m_axi_ddr_wlast(wlast),
        .m_axi_ddr_bvalid(bvalid), .m_axi_ddr_bready(bready), .m_axi_ddr_bresp(bresp),
        .m_axi_ddr_bid(bid),
        .s_axis_ddr_tdata(tdata), .s_axis_ddr_tkeep(tkeep), .s_axis_ddr_tlast(tlast),
        .s_axis_ddr_tvalid(tvalid), .s_axis_ddr_tready(tready)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int stall_en = 0;
    int err_idx = -1;
    bit src_en = 1'b0;
    logic [31:0] src_seq = 0;
    logic [31:0] exp_w_seq = 0;

    logic [63:0] aw_addr_q[$];
    int          aw_len_q[$];
    logic [15:0] aw_const;
    int first_aw_cyc, w_cnt, w_last_cnt, w_last_err, w_order_err, w_data_err, nonfull_cnt;
    int w_bidx, w_beat, b_pend, b_issued, b_last_cyc, done_cnt, done_cyc, acc_cyc;
    logic [31:0] last_strb;
    logic done_err;
    bit b_clear = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        aw_addr_q.delete();
        aw_len_q.delete();
        aw_const = '0;
        first_aw_cyc = -1; w_cnt = 0; w_last_cnt = 0; w_last_err = 0; w_order_err = 0;
        w_data_err = 0; nonfull_cnt = 0; w_bidx = 0; w_beat = 0; b_issued = 0;
        b_last_cyc = -1; done_cnt = 0; done_cyc = -1; last_strb = '0; done_err = 1'b0;
        exp_w_seq = src_seq;
    endtask

    // Slave + stream model: drive on negedge, observe handshakes 1 time unit later
    initial begin
        b_pend = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (b_clear) begin
                bvalid  = 1'b0;
                b_clear = 1'b0;
            end
            if (!aresetn) begin
                bvalid = 1'b0;
                b_pend = 0;
            end
            awready = (stall_en != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = (stall_en != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            tvalid  = src_en && ((stall_en == 0) || ($urandom_range(0, 2) != 0));
            tdata   = {8{src_seq}};
            if (!bvalid && (b_pend > 0) && ((stall_en == 0) || ($urandom_range(0, 1) == 1))) begin
                bvalid = 1'b1;
                bresp  = (b_issued == err_idx) ? 2'b10 : 2'b00;
            end
            #1;
            if (awvalid && awready) begin
                aw_addr_q.push_back(awaddr);
                aw_len_q.push_back(int'(awlen));
                aw_const = {awid, awsize, awburst, awlock, awcache, awprot};
                if (first_aw_cyc < 0) first_aw_cyc = cyc;
            end
            if (tvalid && tready) src_seq++;
            if (wvalid && wready) begin
                w_cnt++;
                if (wdata !== {8{exp_w_seq}}) w_data_err++;
                exp_w_seq++;
                if (wstrb !== 32'hFFFF_FFFF) nonfull_cnt++;
                last_strb = wstrb;
                if (wlast) w_last_cnt++;
                if (w_bidx >= aw_len_q.size()) begin
                    w_order_err++;
                end else begin
                    if (wlast !== (w_beat == aw_len_q[w_bidx])) w_last_err++;
                    if (w_beat == aw_len_q[w_bidx]) begin
                        w_bidx++;
                        w_beat = 0;
                        b_pend++;
                    end else begin
                        w_beat++;
                    end
                end
            end
            if (bvalid && bready) begin
                b_issued++;
                b_pend--;
                b_last_cyc = cyc;
                b_clear = 1'b1;
            end
            if (wr_done) begin
                done_cnt++;
                done_cyc = cyc;
                done_err = wr_err;
            end
        end
    end

    // Issue one command; called and returns at negedge+2
    task automatic do_cmd(input logic [63:0] a, input logic [31:0] l);
        clear_logs();
        wr_paddr = a;
        wr_len   = l;
        wr_valid = 1'b1;
        acc_cyc  = -1;
        for (int i = 0; i < 50 && acc_cyc < 0; i++) begin
            if (wr_ready) acc_cyc = cyc;
            else begin
                @(negedge clk);
                #2;
            end
        end
        chk("cmd_accept", 64'(acc_cyc >= 0), 1);
        @(negedge clk);
        #2;
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            @(negedge clk);
            #2;
        end
        repeat (4) begin
            @(negedge clk);
            #2;
        end
        chk("done_count", done_cnt, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        aresetn = 1'b0; wr_valid = 1'b0; wr_paddr = '0; wr_len = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 2'b00;
        tdata = '0; tkeep = '1; tlast = 1'b0; tvalid = 1'b0;
        clear_logs();
        repeat (3) @(negedge clk);
        #2;
        // reset state
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_bready", bready, 0);
        aresetn = 1'b1;
        src_en  = 1'b1;
        @(negedge clk);
        #2;
        chk("rel_wr_ready", wr_ready, 1);
        chk("rel_bready", bready, 1);

        // len=64 @0x1000: one burst of two beats
        do_cmd(64'h1000, 32'd64);
        wait_done(200);
        chk("t64_aw_cnt", aw_addr_q.size(), 1);
        chk("t64_awaddr", aw_addr_q[0], 64'h1000);
        chk("t64_awlen", aw_len_q[0], 1);
        chk("t64_aw_const", aw_const, {2'b00, 3'd5, 2'b01, 1'b0, 4'b0011, 3'b000});
        chk("t64_aw_latency", first_aw_cyc, acc_cyc + 1);
        chk("t64_beats", w_cnt, 2);
        chk("t64_wlast", {w_last_cnt, w_last_err}, {32'd1, 32'd0});
        chk("t64_strb", {nonfull_cnt, last_strb}, {32'd0, 32'hFFFF_FFFF});
        chk("t64_data", w_data_err, 0);
        chk("t64_done_lat", done_cyc, b_last_cyc + 1);
        chk("t64_err", done_err, 0);

        // len=64 KiB: 32 bursts of 64 beats, 0x800 address step
        do_cmd(64'h10000, 32'd65536);
        wait_done(6000);
        chk("t32b_aw_cnt", aw_addr_q.size(), 32);
        bad = 0;
        for (int i = 0; i < aw_addr_q.size(); i++) begin
            if (aw_len_q[i] != 63) bad++;
            if (aw_addr_q[i] != 64'h10000 + 64'(i) * 64'h800) bad++;
        end
        chk("t32b_shape", bad, 0);
        chk("t32b_beats", w_cnt, 2048);
        chk("t32b_wlast", {w_last_cnt, w_last_err, w_order_err}, {32'd32, 32'd0, 32'd0});
        chk("t32b_data", w_data_err, 0);
        chk("t32b_done_lat", done_cyc, b_last_cyc + 1);

        // 4 KiB split: 0x0FC0, 256 bytes -> 2 beats then 6 beats
        do_cmd(64'h0FC0, 32'd256);
        wait_done(300);
        chk("t4k_aw_cnt", aw_addr_q.size(), 2);
        if (aw_addr_q.size() == 2) begin
            chk("t4k_aw0", {aw_addr_q[0], 64'(aw_len_q[0])}, {64'h0FC0, 64'd1});
            chk("t4k_aw1", {aw_addr_q[1], 64'(aw_len_q[1])}, {64'h1000, 64'd5});
        end
        chk("t4k_beats", w_cnt, 8);
        chk("t4k_wlast", {w_last_cnt, w_last_err}, {32'd2, 32'd0});

        // stalls everywhere, multi-burst with an error response on burst 1
        stall_en = 1;
        err_idx  = 1;
        do_cmd(64'h2000, 32'd6184);
        wait_done(6000);
        chk("terr_aw_cnt", aw_addr_q.size(), 4);
        if (aw_addr_q.size() == 4) begin
            chk("terr_last_aw", {aw_addr_q[3], 64'(aw_len_q[3])}, {64'h3800, 64'd1});
        end
        chk("terr_beats", w_cnt, 194);
        chk("terr_integrity", {w_data_err, w_last_err, w_order_err}, 96'd0);
        chk("terr_strb", {nonfull_cnt, last_strb}, {32'd1, 32'h0000_00FF});
        chk("terr_err", done_err, 1);
        chk("terr_done_lat", done_cyc, b_last_cyc + 1);
        stall_en = 0;
        err_idx  = -1;

        // len=70: 3 beats, partial final strobe, error flag cleared
        do_cmd(64'h5000, 32'd70);
        wait_done(200);
        chk("t70_awlen", aw_len_q.size() == 1 ? aw_len_q[0] : -1, 2);
        chk("t70_beats", w_cnt, 3);
        chk("t70_strb", {nonfull_cnt, last_strb}, {32'd1, 32'h0000_003F});
        chk("t70_wlast", {w_last_cnt, w_last_err}, {32'd1, 32'd0});
        chk("t70_err", done_err, 0);

        // len=0: no traffic, done two cycles after accept
        do_cmd(64'h6000, 32'd0);
        wait_done(50);
        chk("t0_traffic", {32'(aw_addr_q.size()), 32'(w_cnt)}, 64'd0);
        chk("t0_done_lat", done_cyc, acc_cyc + 2);

        // reset mid-burst, then a clean command under stalls
        stall_en = 1;
        do_cmd(64'h3000, 32'd4096);
        repeat (40) @(negedge clk);
        #2;
        chk("mid_busy", wr_ready, 0);
        aresetn = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #2;
        end
        chk("mid_rst_valids", {awvalid, wvalid, tready, wr_ready, bready, wr_done}, 6'b0);
        aresetn = 1'b1;
        @(negedge clk);
        #2;
        chk("mid_rel_ready", {wr_ready, bready, awvalid, wvalid}, 4'b1100);
        do_cmd(64'h4000, 32'd96);
        wait_done(500);
        chk("post_beats", w_cnt, 3);
        chk("post_integrity", {w_data_err, w_last_err, w_order_err}, 96'd0);
        chk("post_aw", aw_addr_q.size() == 1 ? aw_addr_q[0] : 64'hDEAD, 64'h4000);
        chk("post_err", done_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
